tt_mux_ctrl: RTL

- Chip-level project multiplexer that sits directly upstream of the per-project wrappers.
- Selects one of N_PROJ projects from pad control pulses and drives the selected wrapper's ena.
- Builds the shared 18-bit iw input bus from chip pads with a sequenced project reset, and returns the selected project's 24-bit ow to the output pads.

---
 rtl/tt_mux_pkg.sv | 26 ++
 rtl/tt_ctrl_sync.sv | 34 +++
 rtl/tt_mux_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/tt_mux_pkg.sv
// Shared bus geometry and controller state encoding for the project multiplexer.
package tt_mux_pkg;

  // Width of the broadcast input bus and of each project's return bus
  localparam int IW_W = 18;
  localparam int OW_W = 24;

  // Field offsets inside iw: {uio_in, ui_in, rst_n, clk}
  localparam int IW_CLK = 0;
  localparam int IW_RST = 1;
  localparam int IW_UI  = 2;
  localparam int IW_UIO = 10;

  // Field offsets inside ow: {uio_oe, uio_out, uo_out}
  localparam int OW_UO      = 0;
  localparam int OW_UIO_OUT = 8;
  localparam int OW_UIO_OE  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWITCH = 2'd1,
    ST_RESET  = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

endpackage

// File: rtl/tt_ctrl_sync.sv
// Two-flop synchroniser for an asynchronous pad; optionally turns each rising
// edge of the synchronised level into a single clk-cycle pulse.
module tt_ctrl_sync #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic q
);

  logic [1:0] ff;

  // Metastability filter: ff[1] is the clean synchronised level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[0], din};
  end

  if (EDGE) begin : g_edge
    logic prev;

    // Remember last synchronised level so a rise yields one pulse
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev <= 1'b0;
      else        prev <= ff[1];
    end

    assign q = ff[1] & ~prev;
  end else begin : g_level
    assign q = ff[1];
  end

endmodule

// File: rtl/tt_mux_ctrl.sv
// Chip-level project multiplexer: picks one project from pad pulses, runs it
// through a gap / held-reset / run sequence and muxes its outputs to the pads.
module tt_mux_ctrl
  import tt_mux_pkg::*;
#(
  parameter int N_PROJ     = 16,
  parameter int SEL_W      = 4,
  parameter int RST_CYCLES = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ctrl_ena,
  input  logic                     ctrl_sel_inc,
  input  logic                     ctrl_sel_clr,
  input  logic                     pad_clk,
  input  logic                     pad_rst_n,
  input  logic [7:0]               pad_ui_in,
  input  logic [7:0]               pad_uio_in,
  output logic [N_PROJ-1:0]        ena_o,
  output logic [IW_W-1:0]          iw_o,
  input  logic [OW_W*N_PROJ-1:0]   ow_i,
  output logic [7:0]               pad_uo_out,
  output logic [7:0]               pad_uio_out,
  output logic [7:0]               pad_uio_oe
);

  localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES);
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

  logic             ena_s, inc_p, clr_s;
  state_t           state, state_nx;
  logic [SEL_W-1:0] sel, sel_nx;
  logic [7:0]       rst_cnt, rst_cnt_nx, gap_cnt, gap_cnt_nx;
  logic             sel_chg;
  logic [N_PROJ-1:0] ena_nx;
  logic [OW_W-1:0]  ow_sel;
  logic             sel_ok, active, running;

  tt_ctrl_sync #(.EDGE(1'b0)) u_sync_ena (.clk(clk), .rst_n(rst_n), .din(ctrl_ena),     .q(ena_s));
  tt_ctrl_sync #(.EDGE(1'b1)) u_sync_inc (.clk(clk), .rst_n(rst_n), .din(ctrl_sel_inc), .q(inc_p));
  tt_ctrl_sync #(.EDGE(1'b0)) u_sync_clr (.clk(clk), .rst_n(rst_n), .din(ctrl_sel_clr), .q(clr_s));

  // Select counter: clear beats increment; wrap also recovers an out-of-range value
  always_comb begin
    sel_nx = sel;
    if (clr_s) begin
      sel_nx = '0;
    end else if (inc_p) begin
      if (sel >= SEL_W'(N_PROJ - 1)) sel_nx = '0;
      else                           sel_nx = sel + SEL_W'(1);
    end
  end

  assign sel_chg = (sel_nx != sel);

  // Sequencer: dropping ctrl_ena always wins; a select change forces a gap
  always_comb begin
    state_nx   = state;
    rst_cnt_nx = rst_cnt;
    gap_cnt_nx = gap_cnt;
    if (!ena_s) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nx   = ST_RESET;
          rst_cnt_nx = RST_LOAD;
        end
        ST_RESET: begin
          if (sel_chg) begin
            state_nx   = ST_SWITCH;
            gap_cnt_nx = GAP_LOAD;
          end else if (rst_cnt == 8'd1) begin
            state_nx = ST_RUN;
          end else begin
            rst_cnt_nx = rst_cnt - 8'd1;
          end
        end
        ST_RUN: begin
          if (sel_chg) begin
            state_nx   = ST_SWITCH;
            gap_cnt_nx = GAP_LOAD;
          end
        end
        ST_SWITCH: begin
          if (sel_chg) begin
            gap_cnt_nx = GAP_LOAD;
          end else if (gap_cnt == 8'd1) begin
            state_nx   = ST_RESET;
            rst_cnt_nx = RST_LOAD;
          end else begin
            gap_cnt_nx = gap_cnt - 8'd1;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // One-hot enable for the next cycle; an out-of-range select matches no bit
  always_comb begin
    ena_nx = '0;
    if (state_nx == ST_RESET || state_nx == ST_RUN) begin
      for (int k = 0; k < N_PROJ; k++) begin
        if (sel_nx == SEL_W'(k)) ena_nx[k] = 1'b1;
      end
    end
  end

  // Control state and the registered enables
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      sel     <= '0;
      rst_cnt <= '0;
      gap_cnt <= '0;
      ena_o   <= '0;
    end else begin
      state   <= state_nx;
      sel     <= sel_nx;
      rst_cnt <= rst_cnt_nx;
      gap_cnt <= gap_cnt_nx;
      ena_o   <= ena_nx;
    end
  end

  // Pick the selected project's return bus
  always_comb begin
    ow_sel = '0;
    sel_ok = 1'b0;
    for (int k = 0; k < N_PROJ; k++) begin
      if (sel == SEL_W'(k)) begin
        ow_sel = ow_i[k*OW_W +: OW_W];
        sel_ok = 1'b1;
      end
    end
  end

  assign active  = sel_ok && (state == ST_RESET || state == ST_RUN);
  assign running = sel_ok && (state == ST_RUN);

  // Broadcast bus: project reset held low until the sequencer reaches RUN
  always_comb begin
    iw_o = '0;
    if (active) begin
      iw_o[IW_CLK]      = pad_clk;
      iw_o[IW_RST]      = running ? pad_rst_n : 1'b0;
      iw_o[IW_UI +: 8]  = pad_ui_in;
      iw_o[IW_UIO +: 8] = pad_uio_in;
    end
  end

  assign pad_uo_out  = active  ? ow_sel[OW_UO +: 8]      : 8'h00;
  assign pad_uio_out = active  ? ow_sel[OW_UIO_OUT +: 8] : 8'h00;
  assign pad_uio_oe  = running ? ow_sel[OW_UIO_OE +: 8]  : 8'h00;

endmodule
